// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 decrypt sequencer and its S-port mux.
package arc4_pkg;

    localparam int KEY_W  = 24;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int N_ENG  = 3;

    // Engine slot index into the packed request buses
    localparam int REQ_INIT = 0;
    localparam int REQ_KSA  = 1;
    localparam int REQ_PRGA = 2;

    // Encoding of the phase output; the active engine is phase-1
    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_INIT = 2'd1;
    localparam logic [1:0] PH_KSA  = 2'd2;
    localparam logic [1:0] PH_PRGA = 2'd3;

    typedef enum logic [3:0] {
        IDLE,
        LAUNCH0,
        LAUNCH1,
        LAUNCH2,
        WAIT_BUSY0,
        WAIT_BUSY1,
        WAIT_BUSY2,
        WAIT_DONE0,
        WAIT_DONE1,
        WAIT_DONE2
    } seq_state_t;

    // Phase reported for a sequencer state: all three states of phase p map to p+1
    function automatic logic [1:0] state_phase(input seq_state_t s);
        logic [1:0] ph;
        ph = PH_IDLE;
        case (s)
            LAUNCH0, WAIT_BUSY0, WAIT_DONE0: ph = PH_INIT;
            LAUNCH1, WAIT_BUSY1, WAIT_DONE1: ph = PH_KSA;
            LAUNCH2, WAIT_BUSY2, WAIT_DONE2: ph = PH_PRGA;
            default:                         ph = PH_IDLE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/arc4_seq_if.sv
// Bundle of the sequencer's start handshake, engine request lines and S-memory port.
interface arc4_seq_if;
    import arc4_pkg::*;

    // Start handshake and key
    logic                       en;
    logic                       rdy;
    logic [KEY_W-1:0]           key;
    logic [KEY_W-1:0]           key_out;
    logic                       err;
    logic [1:0]                 phase;

    // Per-engine handshake and S-memory requests, engine k in slot k
    logic [N_ENG-1:0]           req_en;
    logic [N_ENG-1:0]           req_rdy;
    logic [N_ENG*ADDR_W-1:0]    req_addr;
    logic [N_ENG*DATA_W-1:0]    req_wrdata;
    logic [N_ENG-1:0]           req_wren;

    // Arbitrated S-memory write/address port
    logic [ADDR_W-1:0]          s_addr;
    logic [DATA_W-1:0]          s_wrdata;
    logic                       s_wren;

    // Environment side: host start request plus the three engines
    modport master (
        output en, key, req_rdy, req_addr, req_wrdata, req_wren,
        input  rdy, key_out, err, phase, req_en, s_addr, s_wrdata, s_wren
    );

    // Sequencer side
    modport slave (
        input  en, key, req_rdy, req_addr, req_wrdata, req_wren,
        output rdy, key_out, err, phase, req_en, s_addr, s_wrdata, s_wren
    );

endinterface

// File: rtl/arc4_seq_s_port_mux.sv
// Combinational 3:1 selector for a memory write/address port, zero when idle.
// The select is a phase code: 0 = idle, 1..3 = slot 0..2.
module s_port_mux
    import arc4_pkg::*;
#(
    parameter int A_W = ADDR_W,
    parameter int D_W = DATA_W
) (
    input  logic [1:0]       i_sel,
    input  logic [3*A_W-1:0] i_addr,
    input  logic [3*D_W-1:0] i_wrdata,
    input  logic [2:0]       i_wren,
    output logic [A_W-1:0]   o_addr,
    output logic [D_W-1:0]   o_wrdata,
    output logic             o_wren
);

    // Route the selected slot through; everything else, including idle, reads as zero
    always_comb begin
        o_addr   = '0;
        o_wrdata = '0;
        o_wren   = 1'b0;
        case (i_sel)
            PH_INIT: begin
                o_addr   = i_addr[REQ_INIT*A_W +: A_W];
                o_wrdata = i_wrdata[REQ_INIT*D_W +: D_W];
                o_wren   = i_wren[REQ_INIT];
            end
            PH_KSA: begin
                o_addr   = i_addr[REQ_KSA*A_W +: A_W];
                o_wrdata = i_wrdata[REQ_KSA*D_W +: D_W];
                o_wren   = i_wren[REQ_KSA];
            end
            PH_PRGA: begin
                o_addr   = i_addr[REQ_PRGA*A_W +: A_W];
                o_wrdata = i_wrdata[REQ_PRGA*D_W +: D_W];
                o_wren   = i_wren[REQ_PRGA];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/arc4_seq.sv
// ARC4 decrypt sequencer: runs init, KSA and PRGA back to back on one start,
// owns the shared S-memory write port, holds the key and aborts stuck phases.
module arc4_seq
    import arc4_pkg::*;
#(
    parameter int TIMEOUT = 8191
) (
    input logic       clk,
    input logic       rst,
    arc4_seq_if.slave bus
);

    // Watchdog width follows TIMEOUT; keep at least one bit when disabled
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int CNT_W = (TO_W > 0) ? TO_W : 1;
    localparam bit WD_ON = (TIMEOUT > 0);
    localparam logic [CNT_W:0] WD_LIMIT = (CNT_W + 1)'(TIMEOUT);
    localparam logic [CNT_W:0] WD_ONE   = (CNT_W + 1)'(1);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [N_ENG-1:0]   r_req_en;
    logic [N_ENG-1:0]   w_req_en_nxt;
    logic [KEY_W-1:0]   r_key;
    logic               r_err;
    logic [CNT_W-1:0]   r_wd;
    logic [CNT_W:0]     w_wd_inc;
    logic               w_accept;
    logic               w_wd_clr;
    logic               w_abort;
    logic [1:0]         w_phase;

    assign w_phase  = state_phase(r_state);
    assign w_wd_inc = {1'b0, r_wd} + WD_ONE;

    // Phase budget exhausted: the counter would reach TIMEOUT on this edge
    assign w_abort  = WD_ON && (r_state != IDLE) && (w_wd_inc == WD_LIMIT);

    // Next-state and launch pulse; a watchdog abort overrides every transition
    always_comb begin
        w_state_nxt  = r_state;
        w_req_en_nxt = '0;
        w_accept     = 1'b0;
        w_wd_clr     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.en) begin
                    w_state_nxt = LAUNCH0;
                    w_accept    = 1'b1;
                    w_wd_clr    = 1'b1;
                end
            end
            LAUNCH0: begin
                if (bus.req_rdy[REQ_INIT]) begin
                    w_state_nxt            = WAIT_BUSY0;
                    w_req_en_nxt[REQ_INIT] = 1'b1;
                end
            end
            LAUNCH1: begin
                if (bus.req_rdy[REQ_KSA]) begin
                    w_state_nxt           = WAIT_BUSY1;
                    w_req_en_nxt[REQ_KSA] = 1'b1;
                end
            end
            LAUNCH2: begin
                if (bus.req_rdy[REQ_PRGA]) begin
                    w_state_nxt            = WAIT_BUSY2;
                    w_req_en_nxt[REQ_PRGA] = 1'b1;
                end
            end
            // Engine must visibly go busy before its rdy can mean "done"
            WAIT_BUSY0: if (!bus.req_rdy[REQ_INIT]) w_state_nxt = WAIT_DONE0;
            WAIT_BUSY1: if (!bus.req_rdy[REQ_KSA])  w_state_nxt = WAIT_DONE1;
            WAIT_BUSY2: if (!bus.req_rdy[REQ_PRGA]) w_state_nxt = WAIT_DONE2;
            WAIT_DONE0: begin
                if (bus.req_rdy[REQ_INIT]) begin
                    w_state_nxt = LAUNCH1;
                    w_wd_clr    = 1'b1;
                end
            end
            WAIT_DONE1: begin
                if (bus.req_rdy[REQ_KSA]) begin
                    w_state_nxt = LAUNCH2;
                    w_wd_clr    = 1'b1;
                end
            end
            WAIT_DONE2: begin
                if (bus.req_rdy[REQ_PRGA]) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt  = IDLE;
            w_req_en_nxt = '0;
        end
    end

    // State, launch pulse, latched key and sticky abort flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_req_en <= '0;
            r_key    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_req_en <= w_req_en_nxt;
            if (w_accept) begin
                r_key <= bus.key;
                r_err <= 1'b0;
            end else if (w_abort) begin
                r_err <= 1'b1;
            end
        end
    end

    // Per-phase watchdog: restarts on each launch, parked at zero while idle
    always_ff @(posedge clk) begin
        if (rst || w_wd_clr || (w_state_nxt == IDLE)) begin
            r_wd <= '0;
        end else begin
            r_wd <= w_wd_inc[CNT_W-1:0];
        end
    end

    assign bus.rdy     = (r_state == IDLE);
    assign bus.phase   = w_phase;
    assign bus.req_en  = r_req_en;
    assign bus.key_out = r_key;
    assign bus.err     = r_err;

    // Zero-latency S-port arbitration keyed by the active phase
    s_port_mux #(
        .A_W (ADDR_W),
        .D_W (DATA_W)
    ) u_s_mux (
        .i_sel    (w_phase),
        .i_addr   (bus.req_addr),
        .i_wrdata (bus.req_wrdata),
        .i_wren   (bus.req_wren),
        .o_addr   (bus.s_addr),
        .o_wrdata (bus.s_wrdata),
        .o_wren   (bus.s_wren)
    );

endmodule

// File: tb/tb_arc4_seq.sv
// Bench for arc4_seq: engine stubs with programmable busy time, a scoreboard
// for launch pulses and run completions, and directed phase/mux/watchdog checks.
`timescale 1ns/1ps
module tb_arc4_seq;
    import arc4_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arc4_seq_if bus0 ();
    arc4_seq_if bus1 ();

    arc4_seq #(.TIMEOUT(8191)) dut    (.clk(clk), .rst(rst), .bus(bus0.slave));
    arc4_seq #(.TIMEOUT(100))  dut_wd (.clk(clk), .rst(rst), .bus(bus1.slave));

    int n_tests = 0;
    int n_fail  = 0;

    // Engine stub knobs, [dut][engine]
    int         len_c   [2][3];
    bit         hold_c  [2][3];
    bit         never_c [2][3];
    logic [7:0] addr_c  [2][3];
    logic [7:0] wr_c    [2][3];
    logic       wren_c  [2][3];

    wire [5:0] req_en_all = {bus1.req_en, bus0.req_en};
    wire [5:0] rdy_all;

    assign bus0.req_rdy    = rdy_all[2:0];
    assign bus1.req_rdy    = rdy_all[5:3];
    assign bus0.req_addr   = {addr_c[0][2], addr_c[0][1], addr_c[0][0]};
    assign bus1.req_addr   = {addr_c[1][2], addr_c[1][1], addr_c[1][0]};
    assign bus0.req_wrdata = {wr_c[0][2], wr_c[0][1], wr_c[0][0]};
    assign bus1.req_wrdata = {wr_c[1][2], wr_c[1][1], wr_c[1][0]};
    assign bus0.req_wren   = {wren_c[0][2], wren_c[0][1], wren_c[0][0]};
    assign bus1.req_wren   = {wren_c[1][2], wren_c[1][1], wren_c[1][0]};

    // Engine stubs: accept en while ready, then stay busy for len cycles
    for (genvar d = 0; d < 2; d++) begin : g_dut
        for (genvar k = 0; k < 3; k++) begin : g_eng
            logic busy;
            int   cnt;
            assign rdy_all[d*3+k] = ~busy & ~hold_c[d][k];
            always @(posedge clk) begin
                if (rst) begin
                    busy <= 1'b0;
                    cnt  <= 0;
                end else if (!busy) begin
                    if (req_en_all[d*3+k] && !hold_c[d][k]) begin
                        busy <= 1'b1;
                        cnt  <= len_c[d][k];
                    end
                end else if (!never_c[d][k]) begin
                    if (cnt <= 1) busy <= 1'b0;
                    else          cnt  <= cnt - 1;
                end
            end
        end
    end

    // Scoreboard queues: expected launch pulses and expected {err,key_out} at completion
    logic [2:0]  exp_req0  [$];
    logic [2:0]  exp_req1  [$];
    logic [24:0] exp_done0 [$];
    logic [24:0] exp_done1 [$];
    logic        prev_rdy0 = 1'b1;
    logic        prev_rdy1 = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0h, required no event", nm, act);
    endtask

    // Monitor: pops the scoreboard whenever a DUT emits a pulse or completes a run
    always @(negedge clk) begin
        if (!rst && bus0.req_en != 3'b000) begin
            if (exp_req0.size() == 0) unexpected("req_en dut0", 32'(bus0.req_en));
            else chk("req_en dut0", 32'(bus0.req_en), 32'(exp_req0.pop_front()));
        end
        if (!rst && bus1.req_en != 3'b000) begin
            if (exp_req1.size() == 0) unexpected("req_en dut1", 32'(bus1.req_en));
            else chk("req_en dut1", 32'(bus1.req_en), 32'(exp_req1.pop_front()));
        end
        if (bus0.rdy === 1'b1 && prev_rdy0 === 1'b0) begin
            if (exp_done0.size() == 0) unexpected("done dut0", 32'({bus0.err, bus0.key_out}));
            else chk("done dut0 {err,key}", 32'({bus0.err, bus0.key_out}), 32'(exp_done0.pop_front()));
        end
        if (bus1.rdy === 1'b1 && prev_rdy1 === 1'b0) begin
            if (exp_done1.size() == 0) unexpected("done dut1", 32'({bus1.err, bus1.key_out}));
            else chk("done dut1 {err,key}", 32'({bus1.err, bus1.key_out}), 32'(exp_done1.pop_front()));
        end
        prev_rdy0 <= bus0.rdy;
        prev_rdy1 <= bus1.rdy;
    end

    function automatic logic [1:0] get_phase(input int d);
        return (d == 0) ? bus0.phase : bus1.phase;
    endfunction

    function automatic logic get_rdy(input int d);
        return (d == 0) ? bus0.rdy : bus1.rdy;
    endfunction

    task automatic start_run(input int d, input logic [23:0] k);
        @(posedge clk); #1;
        if (d == 0) begin bus0.en = 1'b1; bus0.key = k; end
        else        begin bus1.en = 1'b1; bus1.key = k; end
        @(posedge clk); #1;
        if (d == 0) begin bus0.en = 1'b0; bus0.key = ~k; end
        else        begin bus1.en = 1'b0; bus1.key = ~k; end
        @(negedge clk);
    endtask

    task automatic wait_phase(input int d, input logic [1:0] ph, input int budget, input string nm);
        int n = 0;
        while (get_phase(d) !== ph && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(get_phase(d)), 32'(ph));
    endtask

    task automatic wait_rdy(input int d, input int budget, input string nm);
        int n = 0;
        while (get_rdy(d) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(get_rdy(d)), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global time limit: got running, required finished");
        $fatal(1, "time limit");
    end

    initial begin
        logic bad;
        int   n;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) begin
                len_c[d][k]   = 4;
                hold_c[d][k]  = 1'b0;
                never_c[d][k] = 1'b0;
                addr_c[d][k]  = 8'(16 * k + 1);
                wr_c[d][k]    = 8'(16 * k + 2);
                wren_c[d][k]  = 1'b0;
            end
        end
        bus1.en = 1'b0;
        bus1.key = '0;
        // Reset with a simultaneous start request and an engine trying to write
        bus0.en = 1'b1;
        bus0.key = 24'hABCDEF;
        wren_c[0][0] = 1'b1;
        addr_c[0][0] = 8'h77;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset rdy",     32'(bus0.rdy),     32'd1);
        chk("reset req_en",  32'(bus0.req_en),  32'd0);
        chk("reset err",     32'(bus0.err),     32'd0);
        chk("reset phase",   32'(bus0.phase),   32'd0);
        chk("reset key_out", 32'(bus0.key_out), 32'd0);
        chk("reset s_wren",  32'(bus0.s_wren),  32'd0);
        chk("reset s_addr",  32'(bus0.s_addr),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus0.en = 1'b0;
        wren_c[0][0] = 1'b0;
        addr_c[0][0] = 8'h01;

        // Run 1: full sequence, mux during KSA, start request while busy
        len_c[0][0] = 256; len_c[0][1] = 768; len_c[0][2] = 300;
        exp_req0.push_back(3'b001); exp_req0.push_back(3'b010); exp_req0.push_back(3'b100);
        exp_done0.push_back({1'b0, 24'h000318});
        start_run(0, 24'h000318);
        chk("run1 rdy after accept", 32'(bus0.rdy),     32'd0);
        chk("run1 phase init",       32'(bus0.phase),   32'd1);
        chk("run1 key latched",      32'(bus0.key_out), 32'h000318);
        wait_phase(0, PH_KSA, 600, "run1 reach ksa");
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        addr_c[0][0] = 8'h11; wren_c[0][0] = 1'b1;
        addr_c[0][1] = 8'h5A; wr_c[0][1] = 8'hC3; wren_c[0][1] = 1'b1;
        @(negedge clk);
        chk("mux ksa s_addr",   32'(bus0.s_addr),   32'h5A);
        chk("mux ksa s_wrdata", 32'(bus0.s_wrdata), 32'hC3);
        chk("mux ksa s_wren",   32'(bus0.s_wren),   32'd1);
        @(posedge clk); #1;
        wren_c[0][1] = 1'b0;
        @(negedge clk);
        chk("mux ksa wren off s_wren", 32'(bus0.s_wren), 32'd0);
        chk("mux ksa wren off s_addr", 32'(bus0.s_addr), 32'h5A);
        @(posedge clk); #1;
        wren_c[0][0] = 1'b0;
        bus0.en = 1'b1; bus0.key = 24'hFFFFFF;
        @(posedge clk); #1;
        bus0.en = 1'b0; bus0.key = 24'h0;
        @(negedge clk);
        chk("busy start key_out", 32'(bus0.key_out), 32'h000318);
        chk("busy start phase",   32'(bus0.phase),   32'd2);
        chk("busy start rdy",     32'(bus0.rdy),     32'd0);
        wait_phase(0, PH_PRGA, 1000, "run1 reach prga");
        n = 0;
        while (bus0.req_rdy[2] !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        chk("prga goes busy", 32'(bus0.req_rdy[2]), 32'd0);
        n = 0;
        while (bus0.req_rdy[2] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        chk("prga rdy rises",        32'(bus0.req_rdy[2]), 32'd1);
        chk("rdy low at prga done",  32'(bus0.rdy),        32'd0);
        chk("phase at prga done",    32'(bus0.phase),      32'd3);
        @(negedge clk);
        chk("rdy one cycle later",   32'(bus0.rdy),        32'd1);
        chk("phase idle after run",  32'(bus0.phase),      32'd0);
        chk("key_out after run",     32'(bus0.key_out),    32'h000318);
        repeat (3) @(negedge clk);
        chk("run1 all pulses seen",  32'(exp_req0.size()), 32'd0);

        // Run 2: KSA engine not ready when its phase begins
        len_c[0][0] = 5; len_c[0][1] = 20; len_c[0][2] = 5;
        hold_c[0][1] = 1'b1;
        exp_req0.push_back(3'b001); exp_req0.push_back(3'b010); exp_req0.push_back(3'b100);
        exp_done0.push_back({1'b0, 24'h00ABCD});
        start_run(0, 24'h00ABCD);
        wait_phase(0, PH_KSA, 100, "run2 reach ksa");
        bad = 1'b0;
        repeat (10) begin
            if (bus0.phase !== 2'd2 || bus0.req_en !== 3'b000) bad = 1'b1;
            @(negedge clk);
        end
        chk("gate no launch while not ready", 32'(bad), 32'd0);
        hold_c[0][1] = 1'b0;
        @(negedge clk);
        chk("gate launch after ready", 32'(bus0.req_en), 32'h2);
        chk("gate phase ksa",          32'(bus0.phase),  32'd2);
        wait_rdy(0, 200, "run2 completes");

        // Run 3: reset while PRGA is being launched
        len_c[0][0] = 5; len_c[0][1] = 5; len_c[0][2] = 200;
        wren_c[0][2] = 1'b1;
        exp_req0.push_back(3'b001); exp_req0.push_back(3'b010);
        exp_done0.push_back({1'b0, 24'h000000});
        start_run(0, 24'h123456);
        wait_phase(0, PH_PRGA, 100, "run3 reach prga");
        chk("run3 prga write passes", 32'(bus0.s_wren), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst rdy",     32'(bus0.rdy),     32'd1);
        chk("midrst req_en",  32'(bus0.req_en),  32'd0);
        chk("midrst phase",   32'(bus0.phase),   32'd0);
        chk("midrst s_wren",  32'(bus0.s_wren),  32'd0);
        chk("midrst key_out", 32'(bus0.key_out), 32'd0);
        chk("midrst err",     32'(bus0.err),     32'd0);
        wren_c[0][2] = 1'b0;
        repeat (5) @(negedge clk);
        chk("run3 pulses consumed", 32'(exp_req0.size()),  32'd0);
        chk("dut0 completions",     32'(exp_done0.size()), 32'd0);

        // Watchdog on the TIMEOUT=100 instance: KSA never finishes
        len_c[1][0] = 5; len_c[1][1] = 10; len_c[1][2] = 5;
        never_c[1][1] = 1'b1;
        wren_c[1][1] = 1'b1;
        exp_req1.push_back(3'b001); exp_req1.push_back(3'b010);
        exp_done1.push_back({1'b1, 24'h0000AA});
        start_run(1, 24'h0000AA);
        wait_phase(1, PH_KSA, 100, "wd reach ksa");
        bad = 1'b0;
        repeat (99) begin
            @(negedge clk);
            if (bus1.err !== 1'b0 || bus1.phase !== 2'd2) bad = 1'b1;
        end
        chk("wd no abort before limit", 32'(bad), 32'd0);
        @(negedge clk);
        chk("wd err",    32'(bus1.err),    32'd1);
        chk("wd rdy",    32'(bus1.rdy),    32'd1);
        chk("wd phase",  32'(bus1.phase),  32'd0);
        chk("wd s_wren", 32'(bus1.s_wren), 32'd0);
        never_c[1][1] = 1'b0;
        wren_c[1][1] = 1'b0;
        repeat (15) @(negedge clk);
        chk("wd err sticky", 32'(bus1.err), 32'd1);
        exp_req1.push_back(3'b001); exp_req1.push_back(3'b010); exp_req1.push_back(3'b100);
        exp_done1.push_back({1'b0, 24'h0000BB});
        start_run(1, 24'h0000BB);
        chk("wd err cleared on start", 32'(bus1.err),   32'd0);
        chk("wd rerun phase",          32'(bus1.phase), 32'd1);
        wait_rdy(1, 300, "wd rerun completes");
        repeat (3) @(negedge clk);
        chk("dut1 pulses consumed", 32'(exp_req1.size()),  32'd0);
        chk("dut1 completions",     32'(exp_done1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
